// File: rtl/uart_pkg.sv
// Shared definitions for the UART buffer datapath: transmitter state encoding,
// parity-mode constants and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic LINE_IDLE = 1'b1;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded with max(D,1)-1 that strobes o_Bit_End
// on the last cycle of every bit while enabled.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Load,
  input  logic             i_En,
  input  logic [DIV_W-1:0] i_Div,
  output logic             o_Bit_End
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_reload;
  logic [DIV_W-1:0] w_reload;

  // A divisor of zero behaves as one clock per bit.
  assign w_reload  = (i_Div == '0) ? '0 : i_Div - 1'b1;
  assign o_Bit_End = i_En && (r_cnt == '0);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_cnt    <= '0;
      r_reload <= '0;
    end else if (i_Load) begin
      r_cnt    <= w_reload;
      r_reload <= w_reload;
    end else if (i_En) begin
      if (r_cnt == '0) r_cnt <= r_reload;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, DATA_BITS LSB-first,
// optional even/odd parity, one or two stop bits, valid/ready word input.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
  logic                 r_two_stop, w_two_stop_nxt;
  logic                 r_stop2, w_stop2_nxt;
  logic                 r_serial, w_serial_nxt;
  logic                 r_active, w_active_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_ready, w_ready_nxt;

  logic w_accept;
  logic w_bit_end;
  logic w_baud_en;

  assign w_accept  = i_Tx_Valid && r_ready;
  assign w_baud_en = (r_state != ST_IDLE);

  // The timer captures the divisor on accept, so the frame keeps its bit period.
  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Load    (w_accept),
    .i_En      (w_baud_en),
    .i_Div     (i_Clks_Per_Bit),
    .o_Bit_End (w_bit_end)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_two_stop_nxt = r_two_stop;
    w_stop2_nxt    = r_stop2;
    w_serial_nxt   = r_serial;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_serial_nxt = LINE_IDLE;
        if (w_accept) begin
          w_state_nxt    = ST_START;
          w_shift_nxt    = i_Tx_Data;
          w_idx_nxt      = '0;
          w_par_en_nxt   = parity_enabled(i_Parity_Mode);
          w_par_bit_nxt  = (^i_Tx_Data) ^ (i_Parity_Mode == PAR_ODD);
          w_two_stop_nxt = i_Two_Stop;
          w_stop2_nxt    = 1'b0;
          w_serial_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_DATA;
          w_serial_nxt = r_shift[0];
        end
      end
      // Line is driven from r_shift[1] while the register shifts, so the bit
      // on the line always equals r_shift[0] during DATA.
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
            if (r_par_en) begin
              w_state_nxt  = ST_PARITY;
              w_serial_nxt = r_par_bit;
            end else begin
              w_state_nxt  = ST_STOP;
              w_serial_nxt = LINE_IDLE;
            end
          end else begin
            w_idx_nxt    = r_idx + 1'b1;
            w_shift_nxt  = r_shift >> 1;
            w_serial_nxt = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_STOP;
          w_serial_nxt = LINE_IDLE;
        end
      end
      ST_STOP: begin
        w_serial_nxt = LINE_IDLE;
        if (w_bit_end) begin
          if (r_two_stop && !r_stop2) begin
            w_stop2_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_serial_nxt = LINE_IDLE;
      end
    endcase

    w_active_nxt = (w_state_nxt != ST_IDLE);
    w_ready_nxt  = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_serial   <= LINE_IDLE;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_two_stop <= w_two_stop_nxt;
      r_stop2    <= w_stop2_nxt;
      r_serial   <= w_serial_nxt;
      r_active   <= w_active_nxt;
      r_done     <= w_done_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign o_Tx_Ready  = r_ready;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit and a 5-bit instance checked cycle by cycle
// against a waveform model built from frame arithmetic.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid8, valid5;
  logic [7:0]  data8;
  logic [4:0]  data5;
  logic [15:0] div;
  logic [1:0]  pm;
  logic        two;

  logic ready8, serial8, active8, done8;
  logic ready5, serial5, active5, done5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16)) dut8 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_Valid(valid8), .o_Tx_Ready(ready8),
    .i_Tx_Data(data8), .i_Clks_Per_Bit(div), .i_Parity_Mode(pm),
    .i_Two_Stop(two), .o_Tx_Serial(serial8), .o_Tx_Active(active8),
    .o_Tx_Done(done8)
  );

  uart_tx_cfg #(.DATA_BITS(5), .DIV_W(16)) dut5 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_Valid(valid5), .o_Tx_Ready(ready5),
    .i_Tx_Data(data5), .i_Clks_Per_Bit(div), .i_Parity_Mode(pm),
    .i_Two_Stop(two), .o_Tx_Serial(serial5), .o_Tx_Active(active5),
    .o_Tx_Done(done5)
  );

  // {serial, active, ready, done}
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {serial5, active5, ready5, done5} : {serial8, active8, ready8, done8};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned eff_div(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit has_par(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  function automatic int unsigned frame_len(input int unsigned nb, input int unsigned d,
                                            input logic [1:0] m, input bit two_s);
    return eff_div(d) * (1 + nb + (has_par(m) ? 1 : 0) + (two_s ? 2 : 1));
  endfunction

  // Line level k cycles after accept (k = 1..F).
  function automatic logic model_line(input int unsigned k, input logic [8:0] d,
                                      input int unsigned nb, input int unsigned dv,
                                      input logic [1:0] m);
    int unsigned bit_no, ones;
    bit_no = (k - 1) / eff_div(dv);
    if (bit_no == 0) return 1'b0;
    if (bit_no <= nb) return d[bit_no-1];
    if (has_par(m) && bit_no == nb + 1) begin
      ones = 0;
      for (int i = 0; i < int'(nb); i++) if (d[i]) ones++;
      return (m == 2'b01) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    end
    return 1'b1;
  endfunction

  task automatic send(input bit sel, input logic [8:0] d, input int unsigned dv,
                      input logic [1:0] m, input bit two_s, input bit hold);
    logic [3:0] o;
    bit got;
    data8 = d[7:0];
    data5 = d[4:0];
    div   = 16'(dv);
    pm    = m;
    two   = two_s;
    if (sel) valid5 = 1'b1; else valid8 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      o = obs(sel);
      if (o[1]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) chk("ready_wait", 32'(0), 32'(1));
    @(negedge clk);
    if (!hold) begin valid8 = 1'b0; valid5 = 1'b0; end
  endtask

  task automatic check_frame(input bit sel, input logic [8:0] d, input int unsigned dv,
                             input logic [1:0] m, input int unsigned f,
                             input bit par_chk, input logic exp_par, input bit mutate);
    logic [3:0] o;
    int unsigned nb;
    nb = sel ? 5 : 8;
    for (int unsigned k = 1; k <= f; k++) begin
      o = obs(sel);
      chk("frame", o, {model_line(k, d, nb, dv, m), 1'b1, 1'b0, 1'b0});
      if (par_chk && k == eff_div(dv) * (1 + nb) + 1) chk("parity", o[3], exp_par);
      if (mutate && k == 2) begin
        div = 16'd7; pm = 2'b01; two = 1'b1; data8 = 8'h00; data5 = 5'h00;
      end
      @(negedge clk);
    end
    chk("done", obs(sel), 4'b1011);
  endtask

  typedef struct {
    bit          sel;
    logic [8:0]  data;
    int unsigned dv;
    logic [1:0]  m;
    bit          two_s;
    bit          mutate;
    int unsigned exp_f;
    logic        exp_par;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 9'h0A5, 4, 2'b00, 1'b0, 1'b0, 40, 1'b0};
    vecs[1] = '{1'b0, 9'h007, 2, 2'b01, 1'b0, 1'b0, 22, 1'b1};
    vecs[2] = '{1'b0, 9'h007, 2, 2'b10, 1'b0, 1'b0, 22, 1'b0};
    vecs[3] = '{1'b0, 9'h007, 2, 2'b01, 1'b1, 1'b0, 24, 1'b1};
    vecs[4] = '{1'b0, 9'h0FF, 0, 2'b00, 1'b0, 1'b1, 10, 1'b0};
    vecs[5] = '{1'b1, 9'h013, 2, 2'b10, 1'b0, 1'b0, 16, 1'b0};
    vecs[6] = '{1'b0, 9'h03C, 1, 2'b11, 1'b1, 1'b0, 11, 1'b0};
    vecs[7] = '{1'b1, 9'h00A, 3, 2'b01, 1'b1, 1'b0, 27, 1'b0};

    rst = 1'b1; valid8 = 1'b0; valid5 = 1'b0;
    data8 = '0; data5 = '0; div = 16'd4; pm = 2'b00; two = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset8", obs(0), 4'b1000);
      chk("reset5", obs(1), 4'b1000);
    end
    rst = 1'b0;
    chk("rst_release_ready", obs(0), 4'b1000);
    @(negedge clk);
    chk("idle_ready8", obs(0), 4'b1010);
    chk("idle_ready5", obs(1), 4'b1010);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].dv, vecs[i].m, vecs[i].two_s, 1'b0);
      check_frame(vecs[i].sel, vecs[i].data, vecs[i].dv, vecs[i].m, vecs[i].exp_f,
                  has_par(vecs[i].m), vecs[i].exp_par, vecs[i].mutate);
      @(negedge clk);
      chk("done_clear", obs(vecs[i].sel), 4'b1010);
    end

    // Back-to-back: valid held through the Done cycle.
    send(0, 9'h055, 3, 2'b00, 1'b0, 1'b1);
    data8 = 8'h0F;
    check_frame(0, 9'h055, 3, 2'b00, 30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid8 = 1'b0;
    check_frame(0, 9'h00F, 3, 2'b00, 30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_idle", obs(0), 4'b1010);

    // Reset in the middle of a frame.
    send(0, 9'h0C3, 4, 2'b01, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= 15; k++) begin
      chk("pre_reset", obs(0), {model_line(k, 9'h0C3, 8, 4, 2'b01), 1'b1, 1'b0, 1'b0});
      if (k < 15) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", obs(0), 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", obs(0), 4'b1010);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", obs(0), 4'b1010);
    end
    send(0, 9'h0A5, 4, 2'b00, 1'b0, 1'b0);
    check_frame(0, 9'h0A5, 4, 2'b00, 40, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Randomised frames against the waveform model.
    for (int i = 0; i < 24; i++) begin
      bit          s, t;
      logic [8:0]  d;
      int unsigned dv;
      logic [1:0]  m;
      s  = 1'($urandom_range(0, 1));
      d  = 9'($urandom_range(0, 255));
      if (s) d = d & 9'h01F;
      dv = $urandom_range(0, 5);
      m  = 2'($urandom_range(0, 3));
      t  = 1'($urandom_range(0, 1));
      send(s, d, dv, m, t, 1'b0);
      check_frame(s, d, dv, m, frame_len(s ? 5 : 8, dv, m, t), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rand_done_clear", obs(s), 4'b1010);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
